// File: rtl/ccff_chain_loader_if.sv
// Bundles the bitstream handshake, chain serial pins and status of the ccff loader.
// slave is the loader's view, master is the side that drives bitstream words and the chain tail.
interface ccff_chain_loader_if #(
  parameter int CHAIN_LEN = 40,
  parameter int WORD_W    = 32
);
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);

  logic              start;
  logic              verify;
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;
  logic              ccff_head;
  logic              ccff_tail;
  logic              ccff_clk_en;
  logic              IO_ISOL_N;
  logic              busy;
  logic              done;
  logic              error;
  logic [CNT_W-1:0]  err_idx;
  logic [CNT_W-1:0]  bit_count;

  modport master (
    output start, verify, word_data, word_valid, ccff_tail,
    input  word_ready, ccff_head, ccff_clk_en, IO_ISOL_N,
    input  busy, done, error, err_idx, bit_count
  );

  modport slave (
    input  start, verify, word_data, word_valid, ccff_tail,
    output word_ready, ccff_head, ccff_clk_en, IO_ISOL_N,
    output busy, done, error, err_idx, bit_count
  );
endinterface

// File: rtl/ccff_chain_loader.sv
// Serially loads (or re-shifts and verifies) an IO-column ccff chain from a word stream,
// keeping the IOs isolated from the start of a pass until the chain has settled.
module ccff_chain_loader #(
  parameter int CHAIN_LEN   = 40,
  parameter int WORD_W      = 32,
  parameter int ISOL_CYCLES = 4
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset,
  ccff_chain_loader_if.slave    bus
);
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int BL_W  = $clog2(WORD_W + 1);
  localparam int IC_W  = $clog2(ISOL_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISOL,
    S_FETCH,
    S_SHIFT,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic              r_verify;
  logic [WORD_W-1:0] r_shreg;
  logic [BL_W-1:0]   r_bits_left;
  logic [CNT_W-1:0]  r_bit_count;
  logic [IC_W-1:0]   r_phase_cnt;
  logic              r_head;
  logic              r_error;
  logic [CNT_W-1:0]  r_err_idx;
  logic              r_isol_n;

  logic              w_idle_like;
  logic              w_phase_last;
  logic              w_last_bit;
  logic              w_word_end;
  logic              w_mismatch;
  logic [CNT_W-1:0]  w_remain;
  logic              w_word_ready;
  logic              w_clk_en;
  logic              w_busy;
  logic              w_done;

  assign w_idle_like  = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_phase_last = (r_phase_cnt == IC_W'(ISOL_CYCLES - 1));
  assign w_last_bit   = (r_bit_count == CNT_W'(CHAIN_LEN - 1));
  assign w_word_end   = (r_bits_left == BL_W'(1));
  assign w_remain     = CNT_W'(CHAIN_LEN) - r_bit_count;
  // Before shift k the tail presents bit k of the previous load, so it must match what we drive now.
  assign w_mismatch   = r_verify && (r_state == S_SHIFT) && (bus.ccff_tail != r_shreg[0]);

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_word_ready = 1'b0;
    w_clk_en     = 1'b0;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_state_next = S_ISOL;
      end
      S_ISOL: begin
        if (w_phase_last) w_state_next = S_FETCH;
      end
      S_FETCH: begin
        w_word_ready = 1'b1;
        if (bus.word_valid) w_state_next = S_SHIFT;
      end
      S_SHIFT: begin
        w_clk_en = 1'b1;
        if (w_last_bit) begin
          w_state_next = S_SETTLE;
        end else if (w_word_end) begin
          w_state_next = S_FETCH;
        end
      end
      S_SETTLE: begin
        if (w_phase_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_busy = 1'b0;
        w_done = 1'b1;
        if (bus.start) w_state_next = S_ISOL;
      end
      default: begin
        w_state_next = S_IDLE;
        w_busy       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_verify    <= 1'b0;
      r_shreg     <= '0;
      r_bits_left <= '0;
      r_bit_count <= '0;
      r_phase_cnt <= '0;
      r_head      <= 1'b0;
      r_error     <= 1'b0;
      r_err_idx   <= '0;
      r_isol_n    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_verify    <= bus.verify;
            r_error     <= 1'b0;
            r_err_idx   <= '0;
            r_bit_count <= '0;
            r_phase_cnt <= '0;
            r_isol_n    <= 1'b0;
          end
        end
        S_ISOL: begin
          r_phase_cnt <= w_phase_last ? '0 : r_phase_cnt + IC_W'(1);
        end
        S_FETCH: begin
          if (bus.word_valid) begin
            r_shreg <= bus.word_data;
            // The final word may carry more bits than the chain still needs.
            if (int'(w_remain) < WORD_W) begin
              r_bits_left <= BL_W'(w_remain);
            end else begin
              r_bits_left <= BL_W'(WORD_W);
            end
          end
        end
        S_SHIFT: begin
          r_head      <= r_shreg[0];
          r_shreg     <= r_shreg >> 1;
          r_bit_count <= r_bit_count + CNT_W'(1);
          r_bits_left <= r_bits_left - BL_W'(1);
          r_phase_cnt <= '0;
          if (w_mismatch && !r_error) begin
            r_error   <= 1'b1;
            r_err_idx <= r_bit_count;
          end
        end
        S_SETTLE: begin
          r_phase_cnt <= r_phase_cnt + IC_W'(1);
          if (w_phase_last) begin
            r_isol_n <= !r_verify || !r_error;
          end
        end
        default: begin
          r_phase_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.word_ready  = w_word_ready;
  assign bus.ccff_clk_en = w_clk_en;
  assign bus.ccff_head   = (r_state == S_SHIFT) ? r_shreg[0] : r_head;
  assign bus.IO_ISOL_N   = r_isol_n;
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.error       = r_error;
  assign bus.err_idx     = r_err_idx;
  assign bus.bit_count   = r_bit_count;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Drives load/verify passes into ccff_chain_loader with a 40-bit chain model on its serial pins
// and checks results against the bitstream each pass was built from.
module tb_ccff_chain_loader;
  localparam int CL = 40;
  localparam int WW = 32;
  localparam int IC = 4;
  localparam int CW = $clog2(CL + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;

  ccff_chain_loader_if #(.CHAIN_LEN(CL), .WORD_W(WW)) bus ();

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .ISOL_CYCLES(IC)) dut (
    .prog_clk   (clk),
    .prog_reset (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Physical chain: head enters at the top, tail leaves from bit 0.
  logic [CL-1:0] chain = '0;
  always @(posedge clk) if (bus.ccff_clk_en === 1'b1) chain <= {bus.ccff_head, chain[CL-1:1]};
  assign bus.ccff_tail = chain[0];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  bit mon_q[$];
  int en_cnt, pre_cnt, post_cnt, isol_bad, overlap;

  always @(negedge clk) begin
    if (bus.ccff_clk_en === 1'b1) begin
      mon_q.push_back(bus.ccff_head);
      en_cnt++;
    end else if (bus.busy === 1'b1 && en_cnt == 0) begin
      pre_cnt++;
    end else if (bus.busy === 1'b1 && en_cnt >= CL) begin
      post_cnt++;
    end
    if (bus.busy === 1'b1 && bus.IO_ISOL_N !== 1'b0) isol_bad++;
    if (bus.ccff_clk_en === 1'b1 && bus.word_ready === 1'b1) overlap++;
  end

  logic [CL-1:0] model_chain = '0;
  logic [31:0]   last_w0, last_w1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CL-1:0] stream(input logic [31:0] w0, input logic [31:0] w1);
    return {w1[7:0], w0};
  endfunction

  task automatic chk_reset(input string p);
    chk({p, "_word_ready"}, 64'(bus.word_ready), 0);
    chk({p, "_ccff_head"}, 64'(bus.ccff_head), 0);
    chk({p, "_clk_en"}, 64'(bus.ccff_clk_en), 0);
    chk({p, "_isol_n"}, 64'(bus.IO_ISOL_N), 0);
    chk({p, "_busy"}, 64'(bus.busy), 0);
    chk({p, "_done"}, 64'(bus.done), 0);
    chk({p, "_error"}, 64'(bus.error), 0);
    chk({p, "_err_idx"}, 64'(bus.err_idx), 0);
    chk({p, "_bit_count"}, 64'(bus.bit_count), 0);
  endtask

  task automatic run_pass(input string nm, input bit vfy, input logic [31:0] w0,
                          input logic [31:0] w1, input int gap, input bit poke,
                          input int abort_at);
    logic [CL-1:0] exp_vec, obs_vec, diff;
    bit exp_err, xfer, gap_on;
    int exp_idx, widx, gap_seen, cyc;
    exp_vec = stream(w0, w1);
    diff    = vfy ? (model_chain ^ exp_vec) : '0;
    exp_err = (diff != '0);
    exp_idx = 0;
    for (int k = CL - 1; k >= 0; k--) if (diff[k]) exp_idx = k;

    @(negedge clk);
    mon_q.delete();
    en_cnt = 0; pre_cnt = 0; post_cnt = 0; isol_bad = 0; overlap = 0;
    bus.start = 1'b1; bus.verify = vfy; bus.word_valid = 1'b1; bus.word_data = w0;
    @(negedge clk);
    bus.start = 1'b0;
    chk({nm, "_isol_after_start"}, 64'(bus.IO_ISOL_N), 0);
    chk({nm, "_busy_after_start"}, 64'(bus.busy), 1);
    chk({nm, "_count_cleared"}, 64'(bus.bit_count), 0);
    widx = 0; gap_seen = 0; gap_on = 0; cyc = 0;
    while (bus.done !== 1'b1 && cyc < 400) begin
      bus.start  = 1'b0;
      bus.verify = vfy;
      if (abort_at >= 0 && bus.ccff_clk_en === 1'b1 && bus.bit_count == CW'(abort_at)) begin
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset({nm, "_abort"});
        rst = 1'b0; bus.word_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_abort_idle"}, 64'(bus.busy), 0);
        $display("pass %s: aborted at bit %0d", nm, abort_at);
        return;
      end
      if (poke && (cyc == 1 || (bus.ccff_clk_en === 1'b1 && bus.bit_count == CW'(10)))) begin
        bus.start  = 1'b1;
        bus.verify = !vfy;
      end
      if (widx == 1 && gap > 0 && !bus.word_valid) begin
        if (!gap_on && bus.word_ready === 1'b1) gap_on = 1;
        if (gap_on) begin
          if (gap_seen == gap) begin
            bus.word_valid = 1'b1;
          end else begin
            chk({nm, "_gap_ready"}, 64'(bus.word_ready), 1);
            chk({nm, "_gap_clk_en"}, 64'(bus.ccff_clk_en), 0);
            chk({nm, "_gap_count"}, 64'(bus.bit_count), 32);
            gap_seen++;
          end
        end
      end
      xfer = (bus.word_ready === 1'b1) && bus.word_valid;
      @(posedge clk); #1;
      if (xfer) begin
        widx++;
        if (widx == 1) begin
          bus.word_data  = w1;
          bus.word_valid = (gap == 0);
        end else begin
          bus.word_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.start  = 1'b0;
    bus.verify = 1'b0;
    chk({nm, "_timeout"}, 64'(cyc < 400), 1);
    chk({nm, "_done"}, 64'(bus.done), 1);
    chk({nm, "_busy_end"}, 64'(bus.busy), 0);
    chk({nm, "_bit_count"}, 64'(bus.bit_count), CL);
    chk({nm, "_error"}, 64'(bus.error), 64'(exp_err));
    chk({nm, "_err_idx"}, 64'(bus.err_idx), 64'(exp_idx));
    chk({nm, "_isol_n_done"}, 64'(bus.IO_ISOL_N), 64'(!vfy || !exp_err));
    chk({nm, "_shift_cycles"}, 64'(en_cnt), CL);
    chk({nm, "_pre_shift_cycles"}, 64'(pre_cnt), IC + 1);
    chk({nm, "_settle_cycles"}, 64'(post_cnt), IC);
    chk({nm, "_isol_while_busy"}, 64'(isol_bad), 0);
    chk({nm, "_ready_during_shift"}, 64'(overlap), 0);
    chk({nm, "_words_taken"}, 64'(widx), 2);
    chk({nm, "_gap_len"}, 64'(gap_seen), 64'(gap));
    obs_vec = '0;
    for (int k = 0; k < mon_q.size() && k < CL; k++) obs_vec[k] = mon_q[k];
    chk({nm, "_head_seq"}, 64'(obs_vec), 64'(exp_vec));
    chk({nm, "_head_hold"}, 64'(bus.ccff_head), 64'(exp_vec[CL-1]));
    chk({nm, "_chain"}, 64'(chain), 64'(exp_vec));
    bus.word_valid = 1'b1; bus.word_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk({nm, "_no_ready_in_done"}, 64'(bus.word_ready), 0);
    chk({nm, "_done_held"}, 64'(bus.done), 1);
    bus.word_valid = 1'b0;
    model_chain = exp_vec;
    last_w0 = w0; last_w1 = w1;
    $display("pass %s: verify=%0d w0=%08h w1=%08h gap=%0d poke=%0d error=%0d err_idx=%0d",
             nm, vfy, w0, w1, gap, poke, bus.error, bus.err_idx);
  endtask

  initial begin
    logic [31:0] rw0, rw1;
    bit          rv;
    int          fb;
    bus.start = 1'b0; bus.verify = 1'b0; bus.word_data = '0; bus.word_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");

    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("reset_beats_start_busy", 64'(bus.busy), 0);
    chk("reset_beats_start_count", 64'(bus.bit_count), 0);

    run_pass("load", 0, 32'hA5A5_0F0F, 32'h0000_00C3, 0, 0, -1);
    run_pass("verify_ok", 1, 32'hA5A5_0F0F, 32'h0000_00C3, 0, 0, -1);
    run_pass("verify_bad", 1, 32'hA5A5_0F0F ^ 32'h20, 32'h0000_00C3, 0, 0, -1);
    run_pass("stall", 0, 32'hA5A5_0F0F, 32'h0000_00C3, 7, 0, -1);
    run_pass("abort", 0, 32'h1234_5678, 32'h0000_009A, 0, 0, 17);
    run_pass("after_abort", 0, 32'hA5A5_0F0F, 32'h0000_00C3, 0, 0, -1);
    run_pass("poke", 0, 32'h0F0F_A5A5, 32'hFFFF_FF3C, 0, 1, -1);
    run_pass("verify_upper", 1, 32'h0F0F_A5A5, 32'h1234_563C, 0, 0, -1);

    for (int i = 0; i < 6; i++) begin
      rv = 1'($urandom_range(0, 1));
      if (rv) begin
        rw0 = last_w0; rw1 = last_w1;
        if ($urandom_range(0, 1) == 1) begin
          fb = $urandom_range(0, CL - 1);
          if (fb < 32) rw0 = rw0 ^ (32'h1 << fb);
          else         rw1 = rw1 ^ (32'h1 << (fb - 32));
        end
        rw1 = rw1 ^ {$urandom_range(0, 16777215), 8'h00};
      end else begin
        rw0 = $urandom; rw1 = $urandom;
      end
      run_pass($sformatf("rand%0d", i), rv, rw0, rw1, $urandom_range(0, 5),
               1'($urandom_range(0, 1)), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
